// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU-side bus controller.
package cpu_bus_pkg;

  // Decoded target region; values 0..3 double as the mem_sel bit / mem_rdata slice index.
  typedef enum logic [2:0] {
    REG_RAM  = 3'd0,
    REG_IO   = 3'd1,
    REG_SRAM = 3'd2,
    REG_ROM  = 3'd3,
    REG_NONE = 3'd4
  } region_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } bus_state_e;

  // Region from the top three address bits (addr[15:13]).
  function automatic region_e decode_region(input logic [2:0] addr_top);
    case (addr_top)
      3'b000:  return REG_RAM;
      3'b001:  return REG_IO;
      3'b010:  return REG_NONE;
      3'b011:  return REG_SRAM;
      default: return REG_ROM;
    endcase
  endfunction

  // One-hot select for a region; open bus selects nothing.
  function automatic logic [3:0] region_sel(input region_e r);
    case (r)
      REG_RAM:  return 4'b0001;
      REG_IO:   return 4'b0010;
      REG_SRAM: return 4'b0100;
      REG_ROM:  return 4'b1000;
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/cpu_addr_decode.sv
// Combinational address decoder: region plus mirrored, zero-extended local offset.
module cpu_addr_decode
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RAM_AW  = 11,
  parameter int unsigned IO_AW   = 3,
  parameter int unsigned SRAM_AW = 13,
  parameter int unsigned ROM_AW  = 15
) (
  input  logic [ADDR_W-1:0] addr,
  output region_e           region,
  output logic [ROM_AW-1:0] offset
);

  // Mirroring falls out of keeping only the low *_AW bits of the address.
  always_comb begin
    region = decode_region(addr[ADDR_W-1 -: 3]);
    offset = '0;
    case (region)
      REG_RAM:  offset = ROM_AW'(addr[RAM_AW-1:0]);
      REG_IO:   offset = ROM_AW'(addr[IO_AW-1:0]);
      REG_SRAM: offset = ROM_AW'(addr[SRAM_AW-1:0]);
      REG_ROM:  offset = addr[ROM_AW-1:0];
      default:  offset = '0;
    endcase
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// NES CPU bus controller: region decode, per-region wait states, open bus and error flagging.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RAM_AW    = 11,
  parameter int unsigned IO_AW     = 3,
  parameter int unsigned SRAM_AW   = 13,
  parameter int unsigned ROM_AW    = 15,
  parameter int unsigned RAM_WAIT  = 0,
  parameter int unsigned IO_WAIT   = 1,
  parameter int unsigned SRAM_WAIT = 1,
  parameter int unsigned ROM_WAIT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   cpu_addr_out,
  input  logic [DATA_W-1:0]   cpu_data_out,
  input  logic                ren,
  input  logic                wen,
  output logic [DATA_W-1:0]   cpu_data_in,
  output logic                rdy,
  output logic                ack,
  output logic                bus_err,
  output logic [3:0]          mem_sel,
  output logic [ROM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_re,
  output logic                mem_we,
  input  logic [4*DATA_W-1:0] mem_rdata
);

  bus_state_e        state_q;
  region_e           region_q;
  region_e           dec_region;
  logic [ROM_AW-1:0] dec_offset;
  logic              write_q;
  logic              pend_err_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rd_slice;

  cpu_addr_decode #(
    .ADDR_W  (ADDR_W),
    .RAM_AW  (RAM_AW),
    .IO_AW   (IO_AW),
    .SRAM_AW (SRAM_AW),
    .ROM_AW  (ROM_AW)
  ) u_decode (
    .addr   (cpu_addr_out),
    .region (dec_region),
    .offset (dec_offset)
  );

  function automatic logic [3:0] region_wait(input region_e r);
    case (r)
      REG_RAM:  return 4'(RAM_WAIT);
      REG_IO:   return 4'(IO_WAIT);
      REG_SRAM: return 4'(SRAM_WAIT);
      REG_ROM:  return 4'(ROM_WAIT);
      default:  return 4'd0;
    endcase
  endfunction

  assign rdy      = (state_q == IDLE);
  // Only meaningful for mapped regions; open-bus reads never use it.
  assign rd_slice = mem_rdata[DATA_W * 32'(region_q[1:0]) +: DATA_W];

  // Access FSM with wait counter, registered strobes and read-data latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      region_q    <= REG_NONE;
      write_q     <= 1'b0;
      pend_err_q  <= 1'b0;
      cnt_q       <= 4'd0;
      ack         <= 1'b0;
      bus_err     <= 1'b0;
      mem_sel     <= 4'b0000;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_data_in <= '0;
    end else begin
      ack     <= 1'b0;
      bus_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ren || wen) begin
            region_q   <= dec_region;
            write_q    <= wen;
            // Conflicting request or ROM write completes with an error.
            pend_err_q <= (ren && wen) || (wen && dec_region == REG_ROM);
            cnt_q      <= region_wait(dec_region);
            mem_sel    <= region_sel(dec_region);
            mem_addr   <= dec_offset;
            mem_wdata  <= cpu_data_out;
            mem_re     <= !wen && dec_region != REG_NONE;
            mem_we     <= wen && dec_region != REG_NONE && dec_region != REG_ROM;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!write_q && region_q != REG_NONE) begin
              cpu_data_in <= rd_slice;
            end
            mem_sel <= 4'b0000;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            ack     <= 1'b1;
            bus_err <= pend_err_q;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl with a read-data/error scoreboard.
module tb_cpu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr_out = '0;
  logic [7:0]  cpu_data_out = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  cpu_data_in;
  logic        rdy, ack, bus_err;
  logic [3:0]  mem_sel;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata;

  logic [7:0]  ram [0:2047];
  logic [7:0]  io_rd   = 8'h00;
  logic [7:0]  sram_rd = 8'h00;
  logic [7:0]  rom_rd  = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  cpu_bus_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr_out (cpu_addr_out),
    .cpu_data_out (cpu_data_out),
    .ren          (ren),
    .wen          (wen),
    .cpu_data_in  (cpu_data_in),
    .rdy          (rdy),
    .ack          (ack),
    .bus_err      (bus_err),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory models: RAM is a real array so a write can be read back through a mirror.
  assign mem_rdata = {rom_rd, sram_rd, io_rd, ram[mem_addr[10:0]]};
  always @(posedge clk) begin
    if (mem_we && mem_sel[0]) ram[mem_addr[10:0]] <= mem_wdata;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, check every ACCESS cycle, then the ack cycle against the scoreboard.
  task automatic run_req(input string tag, input logic [15:0] a, input logic [7:0] d,
                         input logic r, input logic w, input logic [3:0] esel,
                         input logic chk_addr, input logic [14:0] eaddr, input logic ere,
                         input logic ewe, input int eacc, input logic [7:0] edata,
                         input logic eerr);
    int   n;
    exp_t e;
    exp_t got;
    n = 0;
    while (rdy !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check({tag, ":rdy_before"}, rdy, 1'b1);
    cpu_addr_out = a;
    cpu_data_out = d;
    ren = r;
    wen = w;
    e.data = edata;
    e.err  = eerr;
    sb.push_back(e);
    cyc();
    ren = 1'b0;
    wen = 1'b0;
    n = 0;
    while (ack !== 1'b1 && n < 20) begin
      check({tag, ":access"}, {rdy, mem_sel, mem_re, mem_we, mem_wdata, bus_err},
            {1'b0, esel, ere, ewe, d, 1'b0});
      if (chk_addr) check({tag, ":addr"}, mem_addr, eaddr);
      n++;
      cyc();
    end
    check({tag, ":access_cycles"}, n, eacc);
    check({tag, ":done_sig"}, {ack, rdy, mem_sel, mem_re, mem_we}, {1'b1, 1'b0, 6'b0});
    if (sb.size() == 0) begin
      check({tag, ":sb_empty"}, 1'b1, 1'b0);
    end else begin
      got = sb.pop_front();
      check({tag, ":rdata"}, cpu_data_in, got.data);
      check({tag, ":bus_err"}, bus_err, got.err);
    end
    cyc();
    check({tag, ":idle_after"}, {rdy, ack, bus_err}, 3'b100);
  endtask

  initial begin
    int acks;
    // Reset values while rst is held.
    cyc();
    check("reset", {rdy, ack, bus_err, mem_sel, mem_re, mem_we}, {1'b1, 8'b0});
    check("reset_addr", {mem_addr, mem_wdata, cpu_data_in}, 31'b0);
    cyc();
    rst = 1'b0;
    cyc();
    check("idle", {rdy, ack}, 2'b10);

    // RAM write then read through a mirror.
    run_req("ram_wr", 16'h0002, 8'hA5, 1'b0, 1'b1, 4'b0001, 1'b1, 15'h0002, 1'b0, 1'b1,
            1, 8'h00, 1'b0);
    run_req("ram_rd", 16'h1802, 8'h00, 1'b1, 1'b0, 4'b0001, 1'b1, 15'h0002, 1'b1, 1'b0,
            1, 8'hA5, 1'b0);

    // ROM read with two wait states.
    rom_rd = 8'h80;
    run_req("rom_rd", 16'hFFFC, 8'h00, 1'b1, 1'b0, 4'b1000, 1'b1, 15'h7FFC, 1'b1, 1'b0,
            3, 8'h80, 1'b0);

    // ROM write: no write strobe, error with ack, read data unchanged.
    run_req("rom_wr", 16'h8000, 8'h12, 1'b0, 1'b1, 4'b1000, 1'b1, 15'h0000, 1'b0, 1'b0,
            3, 8'h80, 1'b1);

    // IO read, then open-bus read keeps the last value.
    io_rd = 8'h3C;
    run_req("io_rd", 16'h2002, 8'h00, 1'b1, 1'b0, 4'b0010, 1'b1, 15'h0002, 1'b1, 1'b0,
            2, 8'h3C, 1'b0);
    io_rd = 8'hEE;
    run_req("open_rd", 16'h4800, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 15'h0000, 1'b0, 1'b0,
            1, 8'h3C, 1'b0);

    // Simultaneous ren/wen to SRAM is a write with an error.
    sram_rd = 8'h99;
    run_req("sram_rw", 16'h6010, 8'h55, 1'b1, 1'b1, 4'b0100, 1'b1, 15'h0010, 1'b0, 1'b1,
            2, 8'h3C, 1'b1);

    // IO mirror at the top of its window, then a silently dropped open-bus write.
    io_rd = 8'h11;
    run_req("io_mirror", 16'h3FFA, 8'h00, 1'b1, 1'b0, 4'b0010, 1'b1, 15'h0002, 1'b1, 1'b0,
            2, 8'h11, 1'b0);
    run_req("open_wr", 16'h5000, 8'h77, 1'b0, 1'b1, 4'b0000, 1'b0, 15'h0000, 1'b0, 1'b0,
            1, 8'h11, 1'b0);

    // Reset during the second ACCESS cycle of a ROM read.
    cpu_addr_out = 16'hFFFC;
    ren = 1'b1;
    cyc();
    ren = 1'b0;
    check("rst_mid:acc1", {rdy, mem_sel, mem_re}, {1'b0, 4'b1000, 1'b1});
    cyc();
    check("rst_mid:acc2", {rdy, mem_re}, 2'b01);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_mid:after", {rdy, ack, bus_err, mem_sel, mem_re, mem_we}, {1'b1, 8'b0});
    check("rst_mid:data", cpu_data_in, 8'h00);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack === 1'b1) acks++;
      cyc();
    end
    check("rst_mid:no_ack", acks, 0);
    check("rst_mid:idle", rdy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
